// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB write scheduler.
package ov7670_pkg;

    typedef enum logic [3:0] {
        POWERUP,
        FETCH,
        IDLE,
        LOAD,
        STROBE,
        WAIT_BUSY,
        WAIT_IDLE,
        GAP,
        ERROR
    } sccb_state_t;

    localparam logic [7:0]  OV7670_COM7      = 8'h12;
    localparam int          COM7_SRESET_BIT  = 7;
    localparam logic [15:0] INIT_END         = 16'hFFFF;
    localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'h42;
    localparam int          TIMER_W          = 24;

    // A COM7 write with the reset bit set restarts the sensor and needs a long settle.
    function automatic logic is_soft_reset(input logic [7:0] reg_addr, input logic [7:0] reg_val);
        return (reg_addr == OV7670_COM7) && reg_val[COM7_SRESET_BIT];
    endfunction

endpackage

// File: rtl/sccb_write_scheduler_if.sv
// Byte-level link between the write scheduler and the shared SCCB byte engine.
//
// Handshake: the scheduler presents byte_data/byte_last and pulses byte_strobe
// for exactly one cycle to start a byte. The engine raises byte_busy while the
// byte is on the wire and drops it when done; the scheduler holds byte_data and
// byte_last stable and issues no new strobe until busy has risen and fallen.
interface sccb_write_scheduler_if;
    logic [7:0] byte_data;
    logic       byte_strobe;
    logic       byte_last;
    logic       byte_busy;

    modport master (
        output byte_data,
        output byte_strobe,
        output byte_last,
        input  byte_busy
    );

    modport slave (
        input  byte_data,
        input  byte_strobe,
        input  byte_last,
        output byte_busy
    );
endinterface

// File: rtl/sccb_delay_timer.sv
// Loadable down-counter that saturates at zero; one instance serves the
// power-up hold, the inter-write gap and the engine timeout.
module sccb_delay_timer #(
    parameter int             W         = 24,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RESET_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/sccb_write_scheduler.sv
// Sequences OV7670 register writes (init ROM replay, then host writes) as
// 3-byte SCCB phases through the shared byte engine.
module sccb_write_scheduler
    import ov7670_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR      = DEV_ADDR_DEFAULT,
    parameter int         ROM_AW        = 8,
    parameter int         POWERUP_TICKS = 6000000,
    parameter int         GAP_TICKS     = 10,
    parameter int         SETTLE_TICKS  = 500000,
    parameter int         TIMEOUT_TICKS = 65535
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    input  logic                host_req_valid,
    output logic                host_req_ready,
    input  logic [7:0]          host_reg,
    input  logic [7:0]          host_val,
    sccb_write_scheduler_if.master bus,
    output logic                init_done,
    output logic                busy,
    output logic                error,
    output sccb_state_t         state_dbg,
    output logic [TIMER_W-1:0]  delay_dbg
);

    localparam logic [TIMER_W-1:0] POWERUP_LOAD = TIMER_W'(POWERUP_TICKS);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_TICKS);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_TICKS);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_TICKS);
    localparam logic [1:0]         LAST_IDX     = 2'd2;

    sccb_state_t          state_q, state_d;
    logic                 tmr_load, tmr_dec, tmr_zero;
    logic [TIMER_W-1:0]   tmr_load_val, tmr_value;
    logic [1:0]           byte_idx_q;
    logic [7:0]           cur_reg_q, cur_val_q;
    logic [7:0]           byte_data_q;
    logic                 byte_last_q;
    logic                 rom_exhausted_q;
    logic                 fetch_end;
    logic [TIMER_W-1:0]   gap_load_val;

    sccb_delay_timer #(
        .W         (TIMER_W),
        .RESET_VAL (POWERUP_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Init ends on the end marker, or once the last ROM address has been sent.
    assign fetch_end    = (rom_data == INIT_END) || rom_exhausted_q;
    assign gap_load_val = is_soft_reset(cur_reg_q, cur_val_q) ? SETTLE_LOAD : GAP_LOAD;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= POWERUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timer control; a delay of N spends N+1 cycles in its state.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state_q)
            POWERUP: begin
                if (tmr_zero) state_d = FETCH;
                else          tmr_dec = 1'b1;
            end
            FETCH: begin
                state_d = fetch_end ? IDLE : LOAD;
            end
            IDLE: begin
                if (host_req_valid) state_d = LOAD;
            end
            LOAD: begin
                state_d = STROBE;
            end
            STROBE: begin
                state_d      = WAIT_BUSY;
                tmr_load     = 1'b1;
                tmr_load_val = TIMEOUT_LOAD;
            end
            WAIT_BUSY: begin
                if (bus.byte_busy) begin
                    state_d      = WAIT_IDLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMEOUT_LOAD;
                end else if (tmr_zero) begin
                    state_d = ERROR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (!bus.byte_busy) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d      = GAP;
                        tmr_load     = 1'b1;
                        tmr_load_val = gap_load_val;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (tmr_zero) begin
                    state_d = ERROR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) state_d = init_done ? IDLE : FETCH;
                else          tmr_dec = 1'b1;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // Write datapath: current register/value, byte index, ROM pointer and output bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr        <= '0;
            rom_exhausted_q <= 1'b0;
            init_done       <= 1'b0;
            byte_idx_q      <= 2'd0;
            cur_reg_q       <= 8'h00;
            cur_val_q       <= 8'h00;
            byte_data_q     <= 8'h00;
            byte_last_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    cur_reg_q  <= rom_data[15:8];
                    cur_val_q  <= rom_data[7:0];
                    byte_idx_q <= 2'd0;
                    if (fetch_end) init_done <= 1'b1;
                end
                IDLE: begin
                    if (host_req_valid) begin
                        cur_reg_q  <= host_reg;
                        cur_val_q  <= host_val;
                        byte_idx_q <= 2'd0;
                    end
                end
                LOAD: begin
                    case (byte_idx_q)
                        2'd0: begin
                            byte_data_q <= DEV_ADDR;
                            byte_last_q <= 1'b0;
                        end
                        2'd1: begin
                            byte_data_q <= cur_reg_q;
                            byte_last_q <= 1'b0;
                        end
                        default: begin
                            byte_data_q <= cur_val_q;
                            byte_last_q <= 1'b1;
                        end
                    endcase
                end
                WAIT_IDLE: begin
                    if (!bus.byte_busy && (byte_idx_q != LAST_IDX)) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                GAP: begin
                    if (tmr_zero && !init_done) begin
                        if (rom_addr == {ROM_AW{1'b1}}) rom_exhausted_q <= 1'b1;
                        else                            rom_addr        <= rom_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_data   = byte_data_q;
    assign bus.byte_last   = byte_last_q;
    assign bus.byte_strobe = (state_q == STROBE);
    assign host_req_ready  = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign error           = (state_q == ERROR);
    assign state_dbg       = state_q;
    assign delay_dbg       = tmr_value;

endmodule

// File: tb/tb_sccb_write_scheduler.sv
// Bench for sccb_write_scheduler: byte-engine model, ROM model, expected byte
// stream built from the write rules, and timing windows for delays.
module tb_sccb_write_scheduler;
    import ov7670_pkg::*;

    localparam int AW = 3;
    localparam int PT = 20;
    localparam int GT = 4;
    localparam int ST = 50;
    localparam int TT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [15:0]   rom_mem [0:(1<<AW)-1];
    logic          host_req_valid = 1'b0;
    logic          host_req_ready;
    logic [7:0]    host_reg = 8'h00;
    logic [7:0]    host_val = 8'h00;
    logic          init_done, busy, error;
    sccb_state_t   state_dbg;
    logic [23:0]   delay_dbg;

    sccb_write_scheduler_if bif();

    sccb_write_scheduler #(
        .DEV_ADDR      (8'h42),
        .ROM_AW        (AW),
        .POWERUP_TICKS (PT),
        .GAP_TICKS     (GT),
        .SETTLE_TICKS  (ST),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_reg       (host_reg),
        .host_val       (host_val),
        .bus            (bif),
        .init_done      (init_done),
        .busy           (busy),
        .error          (error),
        .state_dbg      (state_dbg),
        .delay_dbg      (delay_dbg)
    );

    assign rom_data = rom_mem[rom_addr];

    // ---------------- engine model + monitor ----------------
    int   eng_len = 8;
    bit   engine_dead = 1'b0;
    int   eng_cnt = 0;
    bit   eng_pending = 1'b0;
    bit   cur_last = 1'b0;
    bit   ready_early = 1'b0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    int         strobe_cyc_q[$];
    int         value_fall_q[$];

    initial bif.byte_busy = 1'b0;

    // Engine: busy rises one cycle after the strobe and stays up eng_len cycles.
    always @(negedge clk) begin
        if (!reset_n) begin
            bif.byte_busy = 1'b0;
            eng_cnt       = 0;
            eng_pending   = 1'b0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bif.byte_busy = 1'b0;
                    if (cur_last) value_fall_q.push_back(cyc);
                end
            end else if (eng_pending) begin
                eng_pending   = 1'b0;
                bif.byte_busy = 1'b1;
                eng_cnt       = eng_len;
            end
            if (bif.byte_strobe === 1'b1) begin
                obs_q.push_back({bif.byte_last, bif.byte_data});
                strobe_cyc_q.push_back(cyc);
                cur_last = bif.byte_last;
                if (!engine_dead) eng_pending = 1'b1;
            end
            if (host_req_ready === 1'b1 && init_done !== 1'b1) ready_early = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    int errors = 0;
    int checks = 0;
    int rel_cyc = 0;

    function automatic void push_write(input logic [7:0] r, input logic [7:0] v);
        exp_q.push_back({1'b0, 8'h42});
        exp_q.push_back({1'b0, r});
        exp_q.push_back({1'b1, v});
    endfunction

    // Init replay: entries in address order until the end marker or the last address.
    function automatic int model_init();
        int n = 0;
        for (int a = 0; a < (1 << AW); a++) begin
            if (rom_mem[a] == 16'hFFFF) break;
            push_write(rom_mem[a][15:8], rom_mem[a][7:0]);
            n++;
        end
        return n;
    endfunction

    function automatic int model_gap(input logic [7:0] r, input logic [7:0] v);
        return (r == 8'h12 && v[7]) ? ST : GT;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_run();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        strobe_cyc_q.delete();
        value_fall_q.delete();
        ready_early = 1'b0;
        reset_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && obs_q.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_init(input int budget, output bit ok);
        for (int k = 0; k < budget && init_done !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        ok = (init_done === 1'b1);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        for (int k = 0; k < budget && host_req_ready !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        ok = (host_req_ready === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        host_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bif.byte_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bif.byte_strobe); end
        checks++; if (bif.byte_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bif.byte_data); end
        checks++; if (bif.byte_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bif.byte_last); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (host_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", host_req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (delay_dbg !== 24'(PT)) begin errors++; $display("FAIL reset_delay: got %0d want %0d", delay_dbg, PT); end
    endtask

    task automatic test_powerup_init();
        bit ok;
        int n;
        foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h3A04;
        rom_mem[1] = 16'h1214;
        eng_len = 8;
        start_run();
        n = model_init();
        wait_strobes(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL powerup_first_strobe: got none want one within 200 cycles"); end
        if (ok) begin
            checks++; if (strobe_cyc_q[0] - rel_cyc < PT) begin errors++; $display("FAIL powerup_hold: got %0d cycles want >= %0d", strobe_cyc_q[0] - rel_cyc, PT); end
            checks++; if (obs_q[0] !== 9'h042) begin errors++; $display("FAIL powerup_first_byte: got %h want 042", obs_q[0]); end
        end
        wait_init(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_done_timeout: got 0 want 1"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL init_byte_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL init_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b want 0", busy); end
        checks++; if (rom_addr !== AW'(n)) begin errors++; $display("FAIL init_rom_addr: got %0d want %0d", rom_addr, n); end
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", host_req_ready); end
        if (strobe_cyc_q.size() > 3 && value_fall_q.size() > 0) begin
            checks++;
            if (strobe_cyc_q[3] - value_fall_q[0] < GT || strobe_cyc_q[3] - value_fall_q[0] >= ST) begin
                errors++; $display("FAIL init_gap: got %0d cycles want [%0d,%0d)", strobe_cyc_q[3] - value_fall_q[0], GT, ST);
            end
        end
    endtask

    task automatic test_settle();
        bit ok;
        int d;
        foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h1280;
        start_run();
        void'(model_init());
        wait_init(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL settle_init_done: got 0 want 1"); end
        checks++; if (value_fall_q.size() != 1) begin errors++; $display("FAIL settle_writes: got %0d want 1", value_fall_q.size()); end
        if (value_fall_q.size() > 0) begin
            d = cyc - value_fall_q[0];
            checks++; if (d < ST || d > ST + 10) begin errors++; $display("FAIL settle_gap: got %0d cycles want [%0d,%0d]", d, ST, ST + 10); end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL settle_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // One host write with its own checks; requires the DUT to be in IDLE.
    task automatic host_write_txn(input logic [7:0] r, input logic [7:0] v);
        bit ok;
        int d, g;
        obs_q.delete();
        exp_q.delete();
        value_fall_q.delete();
        push_write(r, v);
        g = model_gap(r, v);
        @(negedge clk);
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL host_ready_idle: got %b want 1", host_req_ready); end
        host_reg = r;
        host_val = v;
        host_req_valid = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (host_req_ready !== 1'b0) begin errors++; $display("FAIL host_ready_drop: got %b want 0", host_req_ready); end
        host_req_valid = 1'b0;
        host_reg = ~r;
        host_val = ~v;
        wait_strobes(3, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL host_strobes: got %0d want 3", obs_q.size()); end
        wait_ready(ST + 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL host_ready_return: got 0 want 1"); end
        if (ok && value_fall_q.size() > 0) begin
            d = cyc - value_fall_q[$];
            checks++; if (d < g || d > g + 8) begin errors++; $display("FAIL host_gap: got %0d cycles want [%0d,%0d]", d, g, g + 8); end
        end
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL host_byte_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL host_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_host_write();
        eng_len = 8;
        host_write_txn(8'h40, 8'hD0);
    endtask

    task automatic test_random_host();
        logic [7:0] r, v;
        for (int i = 0; i < 6; i++) begin
            eng_len = $urandom_range(1, 8);
            r = 8'($urandom_range(0, 255));
            v = 8'($urandom_range(0, 255));
            if (i == 2) begin
                r = 8'h12;
                v = v | 8'h80;
            end
            host_write_txn(r, v);
        end
        eng_len = 8;
    endtask

    task automatic test_random_init();
        bit ok;
        int n;
        logic [7:0] hr, hv;
        foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
        n = $urandom_range(1, 4);
        for (int a = 0; a < n; a++) begin
            rom_mem[a] = 16'($urandom_range(0, 65535));
            if (rom_mem[a] == 16'hFFFF) rom_mem[a] = 16'hFFFE;
        end
        hr = 8'($urandom_range(0, 255));
        hv = 8'($urandom_range(0, 127));
        eng_len = $urandom_range(2, 6);
        host_reg = hr;
        host_val = hv;
        host_req_valid = 1'b1;
        start_run();
        void'(model_init());
        push_write(hr, hv);
        wait_init(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rinit_done: got 0 want 1"); end
        checks++; if (rom_addr !== AW'(n)) begin errors++; $display("FAIL rinit_rom_addr: got %0d want %0d", rom_addr, n); end
        @(negedge clk);
        host_req_valid = 1'b0;
        wait_strobes(exp_q.size(), 400, ok);
        wait_ready(ST + 100, ok);
        checks++; if (ready_early !== 1'b0) begin errors++; $display("FAIL rinit_ready_early: got 1 want 0"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rinit_byte_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rinit_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        eng_len = 8;
    endtask

    task automatic test_rom_full();
        bit ok;
        foreach (rom_mem[i]) begin
            rom_mem[i] = 16'($urandom_range(0, 65535));
            if (rom_mem[i] == 16'hFFFF) rom_mem[i] = 16'h0102;
            if (rom_mem[i][15:8] == 8'h12) rom_mem[i][7] = 1'b0;
        end
        eng_len = 2;
        start_run();
        void'(model_init());
        wait_init(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_init_done: got 0 want 1"); end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (rom_addr !== {AW{1'b1}}) begin errors++; $display("FAIL full_rom_addr: got %0d want %0d", rom_addr, (1 << AW) - 1); end
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b want 1", host_req_ready); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_byte_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        eng_len = 8;
    endtask

    task automatic test_timeout();
        bit ok;
        int s0, d;
        foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h3A04;
        engine_dead = 1'b1;
        start_run();
        wait_strobes(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_strobe: got none want one"); end
        s0 = (strobe_cyc_q.size() > 0) ? strobe_cyc_q[0] : cyc;
        while (error !== 1'b1 && cyc - s0 <= 30) begin
            @(negedge clk);
            #1;
        end
        d = cyc - s0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
        checks++; if (d < TT || d > TT + 4) begin errors++; $display("FAIL timeout_latency: got %0d cycles want [%0d,%0d]", d, TT, TT + 4); end
        host_req_valid = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL timeout_no_strobes: got %0d want 1", obs_q.size()); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy: got %b want 1", busy); end
        checks++; if (host_req_ready !== 1'b0) begin errors++; $display("FAIL timeout_ready: got %b want 0", host_req_ready); end
        checks++; if (state_dbg !== ERROR) begin errors++; $display("FAIL timeout_state: got %0d want %0d", state_dbg, ERROR); end
        host_req_valid = 1'b0;
        engine_dead = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h3A04;
        rom_mem[1] = 16'h1214;
        eng_len = 8;
        start_run();
        wait_strobes(5, 400, ok);
        for (int k = 0; k < 20 && bif.byte_busy !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        checks++; if (!ok || bif.byte_busy !== 1'b1) begin errors++; $display("FAIL midrst_setup: got strobes=%0d busy=%b want 5 and 1", obs_q.size(), bif.byte_busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (bif.byte_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", bif.byte_data); end
        checks++; if (bif.byte_strobe !== 1'b0 || bif.byte_last !== 1'b0) begin errors++; $display("FAIL midrst_strobe_last: got %b%b want 00", bif.byte_strobe, bif.byte_last); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL midrst_rom_addr: got %0d want 0", rom_addr); end
        checks++; if (init_done !== 1'b0 || error !== 1'b0 || host_req_ready !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b%b want 000", init_done, error, host_req_ready); end
        start_run();
        void'(model_init());
        wait_init(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_init_done: got 0 want 1"); end
        if (strobe_cyc_q.size() > 0) begin
            checks++; if (strobe_cyc_q[0] - rel_cyc < PT) begin errors++; $display("FAIL midrst_powerup: got %0d cycles want >= %0d", strobe_cyc_q[0] - rel_cyc, PT); end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_byte_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (rom_addr !== AW'(2)) begin errors++; $display("FAIL midrst_rom_addr_end: got %0d want 2", rom_addr); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
        test_reset();
        test_powerup_init();
        test_host_write();
        test_random_host();
        test_settle();
        test_random_init();
        test_rom_full();
        test_timeout();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
